id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_if.sv | 46 ++++
 rtl/id_stage.sv | 140 ++++++++++++++
 tb/tb_id_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// IF/ID, register-file and ID/EX signal bundle for the MIPS decode stage.
// The slave side is the decode stage; the master side is the surrounding pipeline.
interface id_stage_if #(
    parameter int PC_W = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            ex_flush;
    logic [4:0]      R_addr_A;
    logic [4:0]      R_addr_B;
    logic [31:0]     rdata_A;
    logic [31:0]     rdata_B;
    logic            stall;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [31:0]     ex_rs_data;
    logic [31:0]     ex_rt_data;
    logic [31:0]     ex_imm;
    logic [4:0]      ex_rs;
    logic [4:0]      ex_rt;
    logic [4:0]      ex_wr_addr;
    logic [2:0]      ex_alu_op;
    logic            ex_alu_src;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_reg_write;
    logic            ex_branch;
    logic            ex_illegal;

    modport master (
        output if_valid, if_instr, if_pc, ex_flush, rdata_A, rdata_B,
        input  R_addr_A, R_addr_B, stall,
        input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
               ex_wr_addr, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_branch, ex_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, ex_flush, rdata_A, rdata_B,
        output R_addr_A, R_addr_B, stall,
        output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
               ex_wr_addr, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_branch, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// MIPS instruction decode stage: decode, load-use hazard detection and the ID/EX
// pipeline register.
module id_stage #(
    parameter int PC_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    id_stage_if.slave bus
);
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                           ALU_OR  = 3'd3, ALU_SLT = 3'd4, ALU_LUI = 3'd5;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return 32'(signed'(v));
    endfunction

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic        is_nop, legal, writes, uses_rs, uses_rt;
    logic        d_alu_src, d_mem_read, d_mem_write, d_branch;
    logic [2:0]  d_alu_op;
    logic [4:0]  d_wr_addr;
    logic [31:0] d_imm;
    logic        bubble;

    assign op    = bus.if_instr[31:26];
    assign rs    = bus.if_instr[25:21];
    assign rt    = bus.if_instr[20:16];
    assign rd    = bus.if_instr[15:11];
    assign funct = bus.if_instr[5:0];

    assign bus.R_addr_A = rs;
    assign bus.R_addr_B = rt;

    always_comb begin
        is_nop      = (bus.if_instr == 32'h0);
        legal       = 1'b0;
        writes      = 1'b0;
        uses_rt     = 1'b0;
        d_alu_op    = ALU_ADD;
        d_alu_src   = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_branch    = 1'b0;
        d_wr_addr   = 5'd0;
        d_imm       = 32'h0;
        if (!is_nop) begin
            unique case (op)
                6'b000000: begin
                    legal   = 1'b1;
                    unique case (funct)
                        6'b100000: d_alu_op = ALU_ADD;
                        6'b100010: d_alu_op = ALU_SUB;
                        6'b100100: d_alu_op = ALU_AND;
                        6'b100101: d_alu_op = ALU_OR;
                        6'b101010: d_alu_op = ALU_SLT;
                        default:   legal    = 1'b0;
                    endcase
                    writes    = legal;
                    uses_rt   = legal;
                    d_wr_addr = legal ? rd : 5'd0;
                end
                6'b001000: begin
                    legal = 1'b1; writes = 1'b1; d_alu_src = 1'b1; d_wr_addr = rt;
                    d_imm = sext16(bus.if_instr[15:0]);
                end
                6'b001100: begin
                    legal = 1'b1; writes = 1'b1; d_alu_src = 1'b1; d_wr_addr = rt;
                    d_alu_op = ALU_AND; d_imm = {16'h0, bus.if_instr[15:0]};
                end
                6'b001101: begin
                    legal = 1'b1; writes = 1'b1; d_alu_src = 1'b1; d_wr_addr = rt;
                    d_alu_op = ALU_OR; d_imm = {16'h0, bus.if_instr[15:0]};
                end
                6'b001111: begin
                    legal = 1'b1; writes = 1'b1; d_alu_src = 1'b1; d_wr_addr = rt;
                    d_alu_op = ALU_LUI; d_imm = {bus.if_instr[15:0], 16'h0};
                end
                6'b100011: begin
                    legal = 1'b1; writes = 1'b1; d_alu_src = 1'b1; d_wr_addr = rt;
                    d_mem_read = 1'b1; d_imm = sext16(bus.if_instr[15:0]);
                end
                6'b101011: begin
                    legal = 1'b1; d_alu_src = 1'b1; d_mem_write = 1'b1; uses_rt = 1'b1;
                    d_imm = sext16(bus.if_instr[15:0]);
                end
                6'b000100: begin
                    legal = 1'b1; d_branch = 1'b1; uses_rt = 1'b1; d_alu_op = ALU_SUB;
                    d_imm = sext16(bus.if_instr[15:0]);
                end
                default: legal = 1'b0;
            endcase
        end
        uses_rs = legal && (op != 6'b001111);
    end

    // A load in EX whose destination feeds this instruction holds IF/ID for one cycle.
    assign bus.stall = bus.if_valid && bus.ex_valid && bus.ex_mem_read &&
                       (bus.ex_wr_addr != 5'd0) && !bus.ex_flush &&
                       ((uses_rs && rs == bus.ex_wr_addr) || (uses_rt && rt == bus.ex_wr_addr));

    assign bubble = bus.ex_flush || bus.stall || !bus.if_valid;

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus.ex_valid     <= rst ? 1'b0 : 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_rs_data   <= '0;
            bus.ex_rt_data   <= '0;
            bus.ex_imm       <= '0;
            bus.ex_rs        <= '0;
            bus.ex_rt        <= '0;
            bus.ex_wr_addr   <= '0;
            bus.ex_alu_op    <= '0;
            bus.ex_alu_src   <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_branch    <= 1'b0;
            bus.ex_illegal   <= 1'b0;
        end else begin
            bus.ex_valid     <= 1'b1;
            bus.ex_pc        <= bus.if_pc;
            bus.ex_rs_data   <= bus.rdata_A;
            bus.ex_rt_data   <= bus.rdata_B;
            bus.ex_imm       <= d_imm;
            bus.ex_rs        <= rs;
            bus.ex_rt        <= rt;
            bus.ex_wr_addr   <= d_wr_addr;
            bus.ex_alu_op    <= d_alu_op;
            bus.ex_alu_src   <= d_alu_src;
            bus.ex_mem_read  <= d_mem_read;
            bus.ex_mem_write <= d_mem_write;
            bus.ex_reg_write <= writes && (d_wr_addr != 5'd0);
            bus.ex_branch    <= d_branch;
            bus.ex_illegal   <= !legal && !is_nop;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, load-use stall, flush priority and reset.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    id_stage_if #(.PC_W(32)) bus ();
    id_stage #(.PC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic fl, input logic [31:0] a, input logic [31:0] b);
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        bus.ex_flush = fl;
        bus.rdata_A  = a;
        bus.rdata_B  = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick(); tick();
        chk("rst_valid", bus.ex_valid, 0);
        chk("rst_regwr", bus.ex_reg_write, 0);
        chk("rst_memrd", bus.ex_mem_read, 0);
        chk("rst_imm", bus.ex_imm, 0);
        chk("rst_stall", bus.stall, 0);
        rst = 1'b0;

        // ADDI $8,$9,-4
        drive(1'b1, 32'h2128FFFC, 32'h104, 1'b0, 32'd10, 32'd7);
        chk("addi_raddrA", bus.R_addr_A, 9);
        chk("addi_raddrB", bus.R_addr_B, 8);
        chk("addi_stall", bus.stall, 0);
        tick();
        chk("addi_valid", bus.ex_valid, 1);
        chk("addi_imm", bus.ex_imm, 32'hFFFFFFFC);
        chk("addi_wr", bus.ex_wr_addr, 8);
        chk("addi_aluop", bus.ex_alu_op, 0);
        chk("addi_alusrc", bus.ex_alu_src, 1);
        chk("addi_regwr", bus.ex_reg_write, 1);
        chk("addi_rsdata", bus.ex_rs_data, 10);
        chk("addi_pc", bus.ex_pc, 32'h104);

        // LW $8,0($9) then ADD $10,$8,$11: one stall cycle
        drive(1'b1, 32'h8D280000, 32'h108, 1'b0, 32'd1, 32'd2);
        tick();
        chk("lw_memrd", bus.ex_mem_read, 1);
        chk("lw_wr", bus.ex_wr_addr, 8);
        chk("lw_regwr", bus.ex_reg_write, 1);
        drive(1'b1, 32'h010B5020, 32'h10C, 1'b0, 32'hAAAA, 32'h33);
        chk("lu_stall", bus.stall, 1);
        tick();
        chk("lu_bubble_valid", bus.ex_valid, 0);
        chk("lu_bubble_memrd", bus.ex_mem_read, 0);
        drive(1'b1, 32'h010B5020, 32'h10C, 1'b0, 32'h55, 32'h33);
        chk("lu_stall_clear", bus.stall, 0);
        tick();
        chk("add_valid", bus.ex_valid, 1);
        chk("add_wr", bus.ex_wr_addr, 10);
        chk("add_regwr", bus.ex_reg_write, 1);
        chk("add_rsdata", bus.ex_rs_data, 32'h55);
        chk("add_rtdata", bus.ex_rt_data, 32'h33);
        chk("add_alusrc", bus.ex_alu_src, 0);
        chk("add_rt", bus.ex_rt, 11);

        // SLT $10,$8,$11 decodes to op 4
        drive(1'b1, 32'h010B502A, 32'h110, 1'b0, 32'h0, 32'h0);
        tick();
        chk("slt_aluop", bus.ex_alu_op, 4);

        // LW then ADD with a flush in the same cycle
        drive(1'b1, 32'h8D280000, 32'h114, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 32'h010B5020, 32'h118, 1'b1, 32'h0, 32'h0);
        chk("flush_stall", bus.stall, 0);
        tick();
        chk("flush_valid", bus.ex_valid, 0);
        chk("flush_regwr", bus.ex_reg_write, 0);
        chk("flush_wr", bus.ex_wr_addr, 0);

        // LW $0 then ADD using $0
        drive(1'b1, 32'h8D200000, 32'h11C, 1'b0, 32'h0, 32'h0);
        tick();
        chk("lw0_memrd", bus.ex_mem_read, 1);
        chk("lw0_regwr", bus.ex_reg_write, 0);
        drive(1'b1, 32'h000B5020, 32'h120, 1'b0, 32'h0, 32'h0);
        chk("lw0_stall", bus.stall, 0);
        tick();
        chk("lw0_add_valid", bus.ex_valid, 1);

        // ORI / LUI / illegal / NOP / BEQ / SW
        drive(1'b1, 32'h34038000, 32'h124, 1'b0, 32'h0, 32'h0);
        tick();
        chk("ori_imm", bus.ex_imm, 32'h00008000);
        chk("ori_aluop", bus.ex_alu_op, 3);
        chk("ori_wr", bus.ex_wr_addr, 3);
        drive(1'b1, 32'h3C038000, 32'h128, 1'b0, 32'h0, 32'h0);
        tick();
        chk("lui_imm", bus.ex_imm, 32'h80000000);
        chk("lui_aluop", bus.ex_alu_op, 5);
        chk("lui_regwr", bus.ex_reg_write, 1);
        drive(1'b1, 32'hFC000000, 32'h12C, 1'b0, 32'h0, 32'h0);
        tick();
        chk("ill_valid", bus.ex_valid, 1);
        chk("ill_flag", bus.ex_illegal, 1);
        chk("ill_regwr", bus.ex_reg_write, 0);
        drive(1'b1, 32'h00000000, 32'h130, 1'b0, 32'h0, 32'h0);
        tick();
        chk("nop_valid", bus.ex_valid, 1);
        chk("nop_illegal", bus.ex_illegal, 0);
        chk("nop_regwr", bus.ex_reg_write, 0);
        drive(1'b1, 32'h1022FFFF, 32'h134, 1'b0, 32'h0, 32'h0);
        tick();
        chk("beq_aluop", bus.ex_alu_op, 1);
        chk("beq_branch", bus.ex_branch, 1);
        chk("beq_imm", bus.ex_imm, 32'hFFFFFFFF);
        chk("beq_wr", bus.ex_wr_addr, 0);
        drive(1'b1, 32'hACC50004, 32'h138, 1'b0, 32'h0, 32'h0);
        tick();
        chk("sw_memwr", bus.ex_mem_write, 1);
        chk("sw_alusrc", bus.ex_alu_src, 1);
        chk("sw_regwr", bus.ex_reg_write, 0);
        chk("sw_imm", bus.ex_imm, 4);

        // Invalid IF/ID slot loads a bubble
        drive(1'b0, 32'h2128FFFC, 32'h13C, 1'b0, 32'h0, 32'h0);
        tick();
        chk("inv_valid", bus.ex_valid, 0);

        // Reset asserted while stalled
        drive(1'b1, 32'h8D280000, 32'h140, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 32'h010B5020, 32'h144, 1'b0, 32'h0, 32'h0);
        chk("rs_stall_pre", bus.stall, 1);
        rst = 1'b1;
        tick();
        chk("rs_valid", bus.ex_valid, 0);
        chk("rs_memrd", bus.ex_mem_read, 0);
        chk("rs_wr", bus.ex_wr_addr, 0);
        chk("rs_pc", bus.ex_pc, 0);
        chk("rs_stall", bus.stall, 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
